// File: rtl/lvds_pair_packer.sv
// lvds_pair_packer: buffers a byte stream and emits it as byte pairs on two LVDS lanes, preceded by a training burst and a sync word
// Ports:
//   I_clk, I_rst         clock, synchronous active-high reset
//   I_valid, I_data      input byte stream, no backpressure
//   I_train_req          one-cycle pulse: restart training and flush buffered bytes
//   O_ch0_data           older byte of each pair, or TRAIN/SYNC/IDLE word
//   O_ch1_data           newer byte of each pair, or TRAIN/SYNC/IDLE word
//   O_train_active       high while the outputs carry TRAIN_WORD or SYNC_WORD
//   O_ovf                sticky drop flag when LVDS_PACK_OVF_STATUS_EN is defined, else constant 0
module lvds_pair_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int TRAIN_LEN = 64,
  parameter logic [7:0] TRAIN_WORD = 8'hE3,
  parameter logic [7:0] SYNC_WORD = 8'hBC,
  parameter logic [7:0] IDLE_WORD = 8'h00
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_valid,
  input  logic [7:0] I_data,
  input  logic       I_train_req,
  output logic [7:0] O_ch0_data,
  output logic [7:0] O_ch1_data,
  output logic       O_train_active,
  output logic       O_ovf
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {S_TRAIN, S_SYNC, S_PAYLOAD} state_t;
  state_t r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0] r_count;
  logic w_pop, w_push;
  logic [7:0] w_cnt;
  always_comb begin
    w_pop = r_state == S_PAYLOAD && r_count >= (PW+1)'(2) && !I_train_req;
    w_push = I_valid && (r_count < (PW+1)'(FIFO_DEPTH) || w_pop);
    // a training request counts as the first cycle of a fresh burst
    w_cnt = I_train_req ? 8'd0 : r_cnt;
  end
  always_ff @(posedge I_clk)
    if (w_push && !I_train_req) r_mem[r_wr] <= I_data;
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state <= S_TRAIN;
      r_cnt <= 8'd0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
      O_ch0_data <= 8'h00;
      O_ch1_data <= 8'h00;
      O_train_active <= 1'b1;
    end else begin
      if (I_train_req) begin
        r_wr <= '0;
        r_rd <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + PW'(1);
        if (w_pop) r_rd <= r_rd + PW'(2);
        r_count <= r_count + {{PW{1'b0}}, w_push} - (w_pop ? (PW+1)'(2) : '0);
      end
      if (I_train_req || r_state == S_TRAIN) begin
        O_ch0_data <= TRAIN_WORD;
        O_ch1_data <= TRAIN_WORD;
        O_train_active <= 1'b1;
        r_cnt <= w_cnt + 8'd1;
        r_state <= w_cnt == 8'(TRAIN_LEN - 1) ? S_SYNC : S_TRAIN;
      end else if (r_state == S_SYNC) begin
        O_ch0_data <= SYNC_WORD;
        O_ch1_data <= SYNC_WORD;
        O_train_active <= 1'b1;
        r_state <= S_PAYLOAD;
      end else begin
        O_ch0_data <= w_pop ? r_mem[r_rd] : IDLE_WORD;
        O_ch1_data <= w_pop ? r_mem[r_rd + PW'(1)] : IDLE_WORD;
        O_train_active <= 1'b0;
      end
    end
  end
`ifdef LVDS_PACK_OVF_STATUS_EN
  logic r_ovf;
  // bytes discarded by a training flush are not overflows
  always_ff @(posedge I_clk)
    if (I_rst) r_ovf <= 1'b0;
    else if (I_valid && !w_push && !I_train_req) r_ovf <= 1'b1;
  assign O_ovf = r_ovf;
`else
  assign O_ovf = 1'b0;
`endif
endmodule
